// File: rtl/mem_coalesce_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_coalesce_unit
// Purpose  : Multi-pass warp memory coalescer; emits one cache-line request per
//            distinct line touched by the active threads. Optional statistics
//            counters are enabled with the COALESCE_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mem_coalesce_unit #(
    parameter int NUM_THREADS = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 8,
    parameter int WARP_ID_W   = 3,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                                                   clk,
    input  logic                                                   resetb,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic                                                   in_read,
    input  logic                                                   in_write,
    input  logic [WARP_ID_W-1:0]                                   in_warp_id,
    input  logic [REG_ADDR_W-1:0]                                  in_reg_addr,
    input  logic [NUM_THREADS-1:0]                                 in_pam,
    input  logic [NUM_THREADS*ADDR_W-1:0]                          in_addr,
    input  logic [NUM_THREADS*DATA_W-1:0]                          in_wdata,
    output logic                                                   req_valid,
    input  logic                                                   req_ready,
    output logic                                                   req_read,
    output logic                                                   req_write,
    output logic [ADDR_W-$clog2(LINE_WORDS)-$clog2(DATA_W/8)-1:0]  req_line_addr,
    output logic [NUM_THREADS-1:0]                                 req_thread_mask,
    output logic [NUM_THREADS*$clog2(LINE_WORDS)-1:0]              req_word_offset,
    output logic [LINE_WORDS*DATA_W-1:0]                           req_wdata,
    output logic [LINE_WORDS-1:0]                                  req_wmask,
    output logic [WARP_ID_W-1:0]                                   req_warp_id,
    output logic [REG_ADDR_W-1:0]                                  req_reg_addr,
    output logic                                                   req_last
`ifdef COALESCE_STATS_EN
    ,
    output logic [15:0]                                            stat_instr_cnt,
    output logic [15:0]                                            stat_req_cnt
`endif
);

    localparam int WOFF_W   = $clog2(LINE_WORDS);
    localparam int BOFF_W   = $clog2(DATA_W/8);
    localparam int LINE_LSB = WOFF_W + BOFF_W;
    localparam int LINE_W   = ADDR_W - LINE_LSB;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_THREADS-1:0]          pending_q, pending_d;
    logic                            read_q, read_d;
    logic                            write_q, write_d;
    logic [WARP_ID_W-1:0]            warp_id_q, warp_id_d;
    logic [REG_ADDR_W-1:0]           reg_addr_q, reg_addr_d;
    logic [NUM_THREADS*ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_THREADS*DATA_W-1:0]   wdata_q, wdata_d;

    logic [LINE_W-1:0]               lead_line;
    logic [NUM_THREADS-1:0]          thr_mask;
    logic [NUM_THREADS*WOFF_W-1:0]   word_off;
    logic [NUM_THREADS*BOFF_W-1:0]   unused_boff;
    logic [LINE_WORDS*DATA_W-1:0]    line_data;
    logic [LINE_WORDS-1:0]           line_wmask;
    logic                            last;
    logic                            start;
    logic                            handshake;

    assign start     = (state_q == S_IDLE) && in_valid && (in_pam != '0) && (in_read || in_write);
    assign handshake = (state_q == S_ISSUE) && req_ready;

    // Request payload is a pure function of the latched instruction and pending mask.
    always_comb begin
        lead_line   = '0;
        thr_mask    = '0;
        word_off    = '0;
        unused_boff = '0;
        line_data   = '0;
        line_wmask  = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lead_line = addr_q[i*ADDR_W + LINE_LSB +: LINE_W];
            end
        end
        for (int i = 0; i < NUM_THREADS; i++) begin
            thr_mask[i] = pending_q[i] && (addr_q[i*ADDR_W + LINE_LSB +: LINE_W] == lead_line);
            word_off[i*WOFF_W +: WOFF_W] = addr_q[i*ADDR_W + BOFF_W +: WOFF_W];
            unused_boff[i*BOFF_W +: BOFF_W] = addr_q[i*ADDR_W +: BOFF_W];
        end
        // Descending walk so the lowest-index thread owns a shared word.
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (thr_mask[i]) begin
                line_wmask[word_off[i*WOFF_W +: WOFF_W]] = 1'b1;
                line_data[word_off[i*WOFF_W +: WOFF_W]*DATA_W +: DATA_W] = wdata_q[i*DATA_W +: DATA_W];
            end
        end
        last = ((pending_q & ~thr_mask) == '0);
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        read_d     = read_q;
        write_d    = write_q;
        warp_id_d  = warp_id_q;
        reg_addr_d = reg_addr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        in_ready   = 1'b0;
        req_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_d  = in_pam;
                    read_d     = in_read;
                    write_d    = in_write;
                    warp_id_d  = in_warp_id;
                    reg_addr_d = in_reg_addr;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    if (start) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    pending_d = pending_q & ~thr_mask;
                    if (last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        read_q     <= read_d;
        write_q    <= write_d;
        warp_id_q  <= warp_id_d;
        reg_addr_q <= reg_addr_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
    end

    assign req_read        = read_q && !write_q;
    assign req_write       = write_q;
    assign req_line_addr   = lead_line;
    assign req_thread_mask = thr_mask;
    assign req_word_offset = word_off;
    assign req_wdata       = line_data;
    assign req_wmask       = line_wmask;
    assign req_warp_id     = warp_id_q;
    assign req_reg_addr    = reg_addr_q;
    assign req_last        = last;

`ifdef COALESCE_STATS_EN
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] req_cnt_q, req_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        req_cnt_d   = req_cnt_q;
        if (start && (instr_cnt_q != 16'hFFFF)) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
        end
        if (handshake && (req_cnt_q != 16'hFFFF)) begin
            req_cnt_d = req_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            instr_cnt_q <= '0;
            req_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            req_cnt_q   <= req_cnt_d;
        end
    end

    assign stat_instr_cnt = instr_cnt_q;
    assign stat_req_cnt   = req_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_coalesce_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_coalesce_unit
// Purpose  : Self-checking bench for mem_coalesce_unit (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_coalesce_unit;

    logic         clk = 1'b0;
    logic         resetb;
    logic         in_valid;
    logic         in_ready;
    logic         in_read;
    logic         in_write;
    logic [2:0]   in_warp_id;
    logic [4:0]   in_reg_addr;
    logic [7:0]   in_pam;
    logic [255:0] in_addr;
    logic [255:0] in_wdata;
    logic         req_valid;
    logic         req_ready;
    logic         req_read;
    logic         req_write;
    logic [26:0]  req_line_addr;
    logic [7:0]   req_thread_mask;
    logic [23:0]  req_word_offset;
    logic [255:0] req_wdata;
    logic [7:0]   req_wmask;
    logic [2:0]   req_warp_id;
    logic [4:0]   req_reg_addr;
    logic         req_last;
`ifdef COALESCE_STATS_EN
    logic [15:0]  stat_instr_cnt;
    logic [15:0]  stat_req_cnt;
`endif

    mem_coalesce_unit dut (
        .clk             (clk),
        .resetb          (resetb),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_read         (in_read),
        .in_write        (in_write),
        .in_warp_id      (in_warp_id),
        .in_reg_addr     (in_reg_addr),
        .in_pam          (in_pam),
        .in_addr         (in_addr),
        .in_wdata        (in_wdata),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_line_addr   (req_line_addr),
        .req_thread_mask (req_thread_mask),
        .req_word_offset (req_word_offset),
        .req_wdata       (req_wdata),
        .req_wmask       (req_wmask),
        .req_warp_id     (req_warp_id),
        .req_reg_addr    (req_reg_addr),
        .req_last        (req_last)
`ifdef COALESCE_STATS_EN
        ,
        .stat_instr_cnt  (stat_instr_cnt),
        .stat_req_cnt    (stat_req_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0]  line;
        logic [7:0]   mask;
        logic [23:0]  woff;
        logic [255:0] wdata;
        logic [7:0]   wmask;
        logic         rd;
        logic         wr;
        logic         last;
    } req_t;

    typedef struct {
        logic [7:0]  pam;
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] dbase;
        logic        rd;
        logic        wr;
        int          stall;
        int          exp_nreq;
        logic [26:0] exp_line;
        logic [7:0]  exp_mask;
        logic [7:0]  exp_wmask;
        logic [31:0] exp_word0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_instr = 0;
    int          exp_req = 0;
    logic [31:0] a [8];
    logic [31:0] d [8];
    logic [2:0]  cur_warp;
    logic [4:0]  cur_reg;
    req_t        exp_q [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: repeatedly take the lowest pending thread's line and serve all threads on it.
    task automatic model(input logic [7:0] pam, input logic rd, input logic wr);
        logic [7:0] pend;
        req_t       r;
        int         lead;
        int         off;
        exp_q.delete();
        if (pam == 8'h00 || !(rd || wr)) return;
        pend = pam;
        while (pend != 8'h00) begin
            lead = 0;
            while (!pend[lead]) lead++;
            r = '0;
            r.line = 27'(a[lead] / 32);
            for (int i = 0; i < 8; i++) begin
                if (pend[i] && (a[i] / 32) == (a[lead] / 32)) r.mask[i] = 1'b1;
                r.woff[i*3 +: 3] = 3'((a[i] / 4) % 8);
            end
            for (int i = 0; i < 8; i++) begin
                if (r.mask[i]) begin
                    off = int'((a[i] / 4) % 8);
                    if (!r.wmask[off]) begin
                        r.wmask[off] = 1'b1;
                        r.wdata[off*32 +: 32] = d[i];
                    end
                end
            end
            r.rd = rd && !wr;
            r.wr = wr;
            pend = pend & ~r.mask;
            r.last = (pend == 8'h00);
            exp_q.push_back(r);
        end
    endtask

    task automatic do_reset_pulse();
        req_ready = 1'b0;
        resetb = 1'b0;
        #1;
        chk("rst_req_valid", 256'(req_valid), 256'(1'b0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        exp_instr = 0;
        exp_req = 0;
        @(negedge clk);
        resetb = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_req_valid", 256'(req_valid), 256'(1'b0));
            chk("post_rst_in_ready", 256'(in_ready), 256'(1'b1));
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic run_instr(input logic [7:0] pam, input logic rd, input logic wr,
                             input int stall_first, input bit rnd, input int abort_after,
                             output int nseen, output req_t first);
        int   k;
        int   wait_cnt;
        logic rdy;
        req_t act;
        model(pam, rd, wr);
        nseen = 0;
        first = '0;
        cur_warp = 3'($urandom);
        cur_reg  = 5'($urandom);
        chk("in_ready_idle", 256'(in_ready), 256'(1'b1));
        in_valid    = 1'b1;
        in_pam      = pam;
        in_read     = rd;
        in_write    = wr;
        in_warp_id  = cur_warp;
        in_reg_addr = cur_reg;
        for (int i = 0; i < 8; i++) begin
            in_addr[i*32 +: 32]  = a[i];
            in_wdata[i*32 +: 32] = d[i];
        end
        @(negedge clk);
        in_valid    = 1'b0;
        in_pam      = 8'($urandom);
        in_read     = 1'($urandom);
        in_write    = 1'($urandom);
        in_warp_id  = 3'($urandom);
        in_reg_addr = 5'($urandom);
        for (int i = 0; i < 8; i++) begin
            in_addr[i*32 +: 32]  = $urandom;
            in_wdata[i*32 +: 32] = $urandom;
        end
        if (exp_q.size() == 0) begin
            repeat (2) begin
                chk("drop_req_valid", 256'(req_valid), 256'(1'b0));
                chk("drop_in_ready", 256'(in_ready), 256'(1'b1));
                @(negedge clk);
            end
            return;
        end
        exp_instr++;
        k = 0;
        wait_cnt = 0;
        while (k < exp_q.size()) begin
            if (abort_after >= 0 && k == abort_after) begin
                do_reset_pulse();
                return;
            end
            if (k == 0 && wait_cnt < stall_first) rdy = 1'b0;
            else if (rnd) rdy = 1'($urandom);
            else rdy = 1'b1;
            req_ready = rdy;
            act.line  = req_line_addr;
            act.mask  = req_thread_mask;
            act.woff  = req_word_offset;
            act.wdata = req_wdata;
            act.wmask = req_wmask;
            act.rd    = req_read;
            act.wr    = req_write;
            act.last  = req_last;
            if (k == 0) first = act;
            chk("req_valid", 256'(req_valid), 256'(1'b1));
            chk("in_ready_busy", 256'(in_ready), 256'(1'b0));
            chk("req_fields", 256'(act[66:0] ^ {act.wdata[63:0], 3'b0}), 256'(exp_q[k][66:0] ^ {exp_q[k].wdata[63:0], 3'b0}));
            chk("req_line_mask_woff", 256'({act.line, act.mask, act.woff}), 256'({exp_q[k].line, exp_q[k].mask, exp_q[k].woff}));
            chk("req_wdata", act.wdata, exp_q[k].wdata);
            chk("req_ids", 256'({req_warp_id, req_reg_addr}), 256'({cur_warp, cur_reg}));
            @(negedge clk);
            wait_cnt++;
            if (rdy) begin
                k++;
                nseen++;
                exp_req++;
                wait_cnt = 0;
            end else if (wait_cnt > 64) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: got no handshake after %0d cycles, required progress", wait_cnt);
                req_ready = 1'b0;
                return;
            end
        end
        req_ready = 1'b0;
        chk("done_req_valid", 256'(req_valid), 256'(1'b0));
        chk("done_in_ready", 256'(in_ready), 256'(1'b1));
    endtask

    vec_t vt [7];
    int   nseen;
    req_t first;

    initial begin
        vt[0] = '{8'hFF, 32'h100, 32'h4,  32'h0,  1'b0, 1'b1, 0, 1, 27'h08, 8'hFF, 8'hFF, 32'h0};
        vt[1] = '{8'hFF, 32'h0,   32'h20, 32'h0,  1'b1, 1'b0, 0, 8, 27'h00, 8'h01, 8'h01, 32'h0};
        vt[2] = '{8'hFF, 32'h40,  32'h0,  32'hA0, 1'b0, 1'b1, 0, 1, 27'h02, 8'hFF, 8'h01, 32'hA0};
        vt[3] = '{8'h0F, 32'h1C,  32'h4,  32'h10, 1'b1, 1'b1, 3, 2, 27'h00, 8'h01, 8'h80, 32'h0};
        vt[4] = '{8'hA4, 32'h3,   32'h8,  32'h0,  1'b1, 1'b0, 0, 2, 27'h00, 8'h04, 8'h10, 32'h0};
        vt[5] = '{8'h00, 32'h0,   32'h4,  32'h0,  1'b1, 1'b0, 0, 0, 27'h00, 8'h00, 8'h00, 32'h0};
        vt[6] = '{8'hFF, 32'h0,   32'h4,  32'h0,  1'b0, 1'b0, 0, 0, 27'h00, 8'h00, 8'h00, 32'h0};

        resetb = 1'b0;
        in_valid = 1'b0;
        in_read = 1'b0;
        in_write = 1'b0;
        in_warp_id = '0;
        in_reg_addr = '0;
        in_pam = '0;
        in_addr = '0;
        in_wdata = '0;
        req_ready = 1'b0;
        #1;
        chk("reset_req_valid", 256'(req_valid), 256'(1'b0));
        chk("reset_in_ready", 256'(in_ready), 256'(1'b1));
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 8; i++) begin
                a[i] = vt[v].base + vt[v].stride * 32'(i);
                d[i] = vt[v].dbase + 32'(i);
            end
            run_instr(vt[v].pam, vt[v].rd, vt[v].wr, vt[v].stall, 1'b0, -1, nseen, first);
            chk($sformatf("vec%0d_nreq", v), 256'(nseen), 256'(vt[v].exp_nreq));
            if (vt[v].exp_nreq > 0) begin
                chk($sformatf("vec%0d_first", v), 256'({first.line, first.mask, first.wmask, first.wdata[31:0]}),
                    256'({vt[v].exp_line, vt[v].exp_mask, vt[v].exp_wmask, vt[v].exp_word0}));
            end
`ifdef COALESCE_STATS_EN
            chk("stat_instr", 256'(stat_instr_cnt), 256'(exp_instr));
            chk("stat_req", 256'(stat_req_cnt), 256'(exp_req));
`endif
        end

        // Four distinct lines, reset after the second handshake.
        for (int i = 0; i < 8; i++) begin
            a[i] = 32'h20 * 32'(i);
            d[i] = 32'(i);
        end
        run_instr(8'h0F, 1'b1, 1'b0, 0, 1'b0, 2, nseen, first);
        chk("abort_nseen", 256'(nseen), 256'(2));
`ifdef COALESCE_STATS_EN
        chk("stat_instr_rst", 256'(stat_instr_cnt), 256'(0));
        chk("stat_req_rst", 256'(stat_req_cnt), 256'(0));
`endif

        for (int t = 0; t < 40; t++) begin
            logic [31:0] base;
            logic [7:0]  pam;
            logic [2:0]  sel;
            base = $urandom & 32'hFFFF_FF00;
            for (int i = 0; i < 8; i++) begin
                a[i] = base + $urandom_range(0, 255);
                d[i] = $urandom;
            end
            pam = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            sel = 3'($urandom);
            run_instr(pam, sel != 3'd0 && sel[0], sel != 3'd0 && !sel[0] || sel == 3'd7,
                      0, 1'b1, -1, nseen, first);
            chk("rand_nreq", 256'(nseen), 256'(exp_q.size()));
        end
`ifdef COALESCE_STATS_EN
        chk("stat_instr_end", 256'(stat_instr_cnt), 256'(exp_instr));
        chk("stat_req_end", 256'(stat_req_cnt), 256'(exp_req));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
